// File: rtl/bsg_round_robin_n_to_n_buffered_if.sv
// bsg_round_robin_n_to_n_buffered_if: lane handshake bundle between producer, striper and lane consumers
interface bsg_round_robin_n_to_n_buffered_if #(
    parameter int width_p = 16,
    parameter int num_channels_p = 4
);
    logic [num_channels_p*width_p-1:0] data_i;
    logic [num_channels_p-1:0] v_i;
    logic [num_channels_p-1:0] ready_o;
    logic [num_channels_p*width_p-1:0] data_o;
    logic [num_channels_p-1:0] v_o;
    logic [num_channels_p-1:0] ready_i;
    logic [$clog2(num_channels_p)-1:0] head_o;
    modport master (output data_i, v_i, ready_i, input ready_o, data_o, v_o, head_o);
    modport slave (input data_i, v_i, ready_i, output ready_o, data_o, v_o, head_o);
endinterface

// File: rtl/bsg_round_robin_n_to_n_buffered.sv
// bsg_round_robin_n_to_n_buffered: rotating-head stripe distributor with optional per-output-lane FIFOs
module bsg_round_robin_n_to_n_buffered #(
    parameter int width_p = 16,
    parameter int num_channels_p = 4,
    parameter int fifo_els_p = 2
) (
    input logic clk_i,
    input logic reset_n_i,
    bsg_round_robin_n_to_n_buffered_if.slave io
);
    localparam int n = num_channels_p;
    localparam int hw = $clog2(n);
    logic [hw-1:0] head_q, head_d;
    logic [n-1:0] lane_rdy, rot_v;
    logic [n-1:0][width_p-1:0] rot_data;
    int pc;
    // output lane j is fed by input (j + head) mod n; ready flows back along the same route
    always_comb begin
        rot_v = '0;
        rot_data = '0;
        io.ready_o = '0;
        for (int j = 0; j < n; j++)
            for (int i = 0; i < n; i++)
                if (i == (j + int'(head_q)) % n) begin
                    rot_v[j] = io.v_i[i];
                    rot_data[j] = io.data_i[i*width_p +: width_p];
                    io.ready_o[i] = lane_rdy[j];
                end
    end
    always_comb begin
        pc = 0;
        for (int i = 0; i < n; i++) pc += int'(io.v_i[i] & io.ready_o[i]);
        head_d = hw'((int'(head_q) + pc) % n);
    end
    always_ff @(posedge clk_i) head_q <= reset_n_i ? head_d : '0;
    assign io.head_o = head_q;
    if (fifo_els_p == 0) begin : g_bypass
        assign lane_rdy = io.ready_i;
        assign io.v_o = rot_v;
        assign io.data_o = rot_data;
    end else begin : g_fifo
        localparam int pw = $clog2(fifo_els_p);
        localparam int cw = $clog2(fifo_els_p + 1);
        logic [n-1:0][fifo_els_p-1:0][width_p-1:0] mem_q, mem_d;
        logic [n-1:0][pw-1:0] wp_q, wp_d, rp_q, rp_d;
        logic [n-1:0][cw-1:0] cnt_q, cnt_d;
        logic [n-1:0] full, enq, deq;
        always_comb begin
            full = '0;
            for (int j = 0; j < n; j++) full[j] = cnt_q[j] == cw'(fifo_els_p);
        end
        assign lane_rdy = ~full;
        // full blocks enqueue even when the same cycle dequeues
        always_comb begin
            mem_d = mem_q;
            enq = '0;
            deq = '0;
            wp_d = wp_q;
            rp_d = rp_q;
            cnt_d = cnt_q;
            io.v_o = '0;
            io.data_o = '0;
            for (int j = 0; j < n; j++) begin
                enq[j] = rot_v[j] & ~full[j];
                deq[j] = (cnt_q[j] != '0) & io.ready_i[j];
                wp_d[j] = enq[j] ? (wp_q[j] == pw'(fifo_els_p - 1) ? '0 : wp_q[j] + pw'(1)) : wp_q[j];
                rp_d[j] = deq[j] ? (rp_q[j] == pw'(fifo_els_p - 1) ? '0 : rp_q[j] + pw'(1)) : rp_q[j];
                cnt_d[j] = cnt_q[j] + cw'(enq[j]) - cw'(deq[j]);
                if (enq[j]) mem_d[j][wp_q[j]] = rot_data[j];
                io.v_o[j] = cnt_q[j] != '0;
                io.data_o[j*width_p +: width_p] = mem_q[j][rp_q[j]];
            end
        end
        always_ff @(posedge clk_i) begin
            wp_q <= reset_n_i ? wp_d : '0;
            rp_q <= reset_n_i ? rp_d : '0;
            cnt_q <= reset_n_i ? cnt_d : '0;
            mem_q <= mem_d;
        end
    end
    if (num_channels_p < 2 || (fifo_els_p != 0 && fifo_els_p < 2)) begin : g_bad_params
        $error("bsg_round_robin_n_to_n_buffered: need num_channels_p >= 2 and fifo_els_p of 0 or >= 2");
    end
    for (genvar i = 0; i < n; i++) begin : g_hold
        assert property (@(posedge clk_i) disable iff (!reset_n_i)
            io.v_i[i] && !io.ready_o[i] |=> io.v_i[i] && $stable(io.data_i[i*width_p +: width_p]));
    end
endmodule

// File: tb/tb_bsg_round_robin_n_to_n_buffered.sv
// tb_bsg_round_robin_n_to_n_buffered: vector table, corner sequences and queue-model random run
module tb_bsg_round_robin_n_to_n_buffered;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;

    bsg_round_robin_n_to_n_buffered_if #(.width_p(8), .num_channels_p(4)) if4();
    bsg_round_robin_n_to_n_buffered_if #(.width_p(8), .num_channels_p(3)) if3();
    bsg_round_robin_n_to_n_buffered_if #(.width_p(8), .num_channels_p(2)) if2();

    bsg_round_robin_n_to_n_buffered #(.width_p(8), .num_channels_p(4), .fifo_els_p(2))
        u4 (.clk_i(clk), .reset_n_i(rst_n), .io(if4));
    bsg_round_robin_n_to_n_buffered #(.width_p(8), .num_channels_p(3), .fifo_els_p(2))
        u3 (.clk_i(clk), .reset_n_i(rst_n), .io(if3));
    bsg_round_robin_n_to_n_buffered #(.width_p(8), .num_channels_p(2), .fifo_els_p(0))
        u2 (.clk_i(clk), .reset_n_i(rst_n), .io(if2));

    typedef struct {
        logic [3:0] v;
        logic [31:0] d;
        logic [3:0] ri;
        logic [3:0] ev;
        logic [1:0] eh;
        logic [3:0] er;
        logic [31:0] ed;
        logic [3:0] edm;
    } vec_t;
    vec_t tbl [7];

    logic [3:0] rv, rri, pend, ev, er;
    logic [31:0] rd, ed;
    logic [7:0] q [4][$];
    int head, npc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mask_lanes(input logic [31:0] d, input logic [3:0] m);
        for (int j = 0; j < 4; j++) if (!m[j]) d[j*8 +: 8] = '0;
        return d;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        if4.v_i = 0; if4.data_i = 0; if4.ready_i = 0;
        if3.v_i = 0; if3.data_i = 0; if3.ready_i = 0;
        if2.v_i = 0; if2.data_i = 0; if2.ready_i = 2'b10;
        tbl[0] = '{4'b0011, 32'h0000A2A1, 4'b0000, 4'b0011, 2'd2, 4'b1111, 32'h0000A2A1, 4'b0011};
        tbl[1] = '{4'b0011, 32'h0000B2B1, 4'b0000, 4'b1111, 2'd0, 4'b1111, 32'hB2B1A2A1, 4'b1111};
        tbl[2] = '{4'b0001, 32'h000000C1, 4'b0000, 4'b1111, 2'd1, 4'b1101, 32'hB2B1A2A1, 4'b1111};
        tbl[3] = '{4'b0010, 32'h0000D100, 4'b0000, 4'b1111, 2'd1, 4'b1101, 32'hB2B1A2A1, 4'b1111};
        tbl[4] = '{4'b0010, 32'h0000D100, 4'b0001, 4'b1111, 2'd1, 4'b1111, 32'hB2B1A2C1, 4'b1111};
        tbl[5] = '{4'b0010, 32'h0000D100, 4'b0001, 4'b1111, 2'd2, 4'b1111, 32'hB2B1A2D1, 4'b1111};
        tbl[6] = '{4'b0000, 32'h00000000, 4'b1111, 4'b0000, 2'd2, 4'b1111, 32'h00000000, 4'b0000};

        repeat (2) @(negedge clk);
        chk("rst v_o", if4.v_o, 0);
        chk("rst ready_o", if4.ready_o, 4'hf);
        chk("rst head", if4.head_o, 0);
        chk("rst3 ready_o", if3.ready_o, 3'b111);
        chk("rst2 ready_o", if2.ready_o, 2'b10);
        chk("rst2 head", if2.head_o, 0);
        rst_n = 1;

        for (int k = 0; k < 7; k++) begin
            if4.v_i = tbl[k].v;
            if4.data_i = tbl[k].d;
            if4.ready_i = tbl[k].ri;
            @(negedge clk);
            chk($sformatf("vec%0d v_o", k), if4.v_o, tbl[k].ev);
            chk($sformatf("vec%0d head", k), if4.head_o, tbl[k].eh);
            chk($sformatf("vec%0d ready_o", k), if4.ready_o, tbl[k].er);
            chk($sformatf("vec%0d data", k), mask_lanes(if4.data_o, tbl[k].edm), tbl[k].ed);
        end

        if4.ready_i = 0;
        if4.v_i = 4'b1111;
        if4.data_i = 32'h44332211;
        @(negedge clk);
        chk("midrst fill v_o", if4.v_o, 4'b1111);
        chk("midrst fill data", if4.data_o, 32'h22114433);
        if4.v_i = 4'b0001;
        if4.data_i = 32'h00000055;
        @(negedge clk);
        chk("midrst fill head", if4.head_o, 3);
        if4.v_i = 0;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("midrst v_o", if4.v_o, 0);
        chk("midrst head", if4.head_o, 0);
        chk("midrst ready_o", if4.ready_o, 4'hf);
        if4.v_i = 4'b0001;
        if4.data_i = 32'h000000E1;
        @(negedge clk);
        if4.v_i = 0;
        chk("postrst v_o", if4.v_o, 4'b0001);
        chk("postrst data0", if4.data_o[7:0], 8'hE1);
        chk("postrst head", if4.head_o, 1);

        if3.ready_i = 3'b111;
        if3.v_i = 3'b011;
        if3.data_i = 24'h003130;
        @(negedge clk);
        chk("n3 head a", if3.head_o, 2);
        chk("n3 v_o a", if3.v_o, 3'b011);
        chk("n3 data a", if3.data_o[15:0], 16'h3130);
        if3.data_i = 24'h004140;
        @(negedge clk);
        if3.v_i = 0;
        chk("n3 head wrap", if3.head_o, 1);
        chk("n3 v_o wrap", if3.v_o, 3'b110);
        chk("n3 data wrap", if3.data_o[23:8], 16'h4140);

        if2.ready_i = 2'b11;
        if2.v_i = 2'b11;
        if2.data_i = 16'hB1B0;
        #1;
        chk("byp data straight", if2.data_o, 16'hB1B0);
        chk("byp v_o", if2.v_o, 2'b11);
        @(negedge clk);
        chk("byp head both", if2.head_o, 0);
        if2.v_i = 2'b01;
        @(negedge clk);
        chk("byp head one", if2.head_o, 1);
        if2.v_i = 2'b11;
        if2.data_i = 16'hD1D0;
        if2.ready_i = 2'b01;
        #1;
        chk("byp data swap", if2.data_o, 16'hD0D1);
        chk("byp ready_o", if2.ready_o, 2'b10);
        @(negedge clk);
        chk("byp head partial", if2.head_o, 0);
        if2.ready_i = 2'b11;
        @(negedge clk);
        chk("byp head drain", if2.head_o, 0);
        if2.v_i = 0;

        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        head = 0;
        pend = 0;
        rv = 0;
        rd = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++)
                if (!pend[i]) begin
                    rv[i] = 1'($urandom_range(0, 1));
                    rd[i*8 +: 8] = 8'($urandom);
                end
            rri = 4'($urandom);
            if4.v_i = rv;
            if4.data_i = rd;
            if4.ready_i = rri;
            #1;
            for (int j = 0; j < 4; j++) begin
                ev[j] = q[j].size() != 0;
                ed[j*8 +: 8] = ev[j] ? q[j][0] : 8'h00;
            end
            for (int i = 0; i < 4; i++) er[i] = q[(i + 4 - head) % 4].size() < 2;
            chk("rnd v_o", if4.v_o, ev);
            chk("rnd ready_o", if4.ready_o, er);
            chk("rnd head", if4.head_o, 64'(head));
            chk("rnd data", mask_lanes(if4.data_o, ev), ed);
            for (int j = 0; j < 4; j++) if (ev[j] && rri[j]) void'(q[j].pop_front());
            npc = 0;
            for (int i = 0; i < 4; i++)
                if (rv[i] && er[i]) begin
                    q[(i + 4 - head) % 4].push_back(rd[i*8 +: 8]);
                    npc++;
                end
            head = (head + npc) % 4;
            pend = rv & ~er;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
